// File: rtl/crc16_frame_ctrl.sv
// Frame controller between the UART byte stream and the application.
// Hunts for SOF, reads a length byte, the payload and a big-endian CRC-16
// trailer. Reports one pass/fail status per frame, forwards payload bytes
// and keeps saturating good/bad frame counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | hunting for SOF; every other byte is discarded
// S_LEN     | SOF seen, waiting for the length byte
// S_PAYLOAD | forwarding payload bytes and folding them into the CRC
// S_CRC_HI  | waiting for trailer[15:8]
// S_CRC_LO  | waiting for trailer[7:0]
// S_DONE    | status cycle; a byte arriving here is handled as in S_IDLE
module crc16_frame_ctrl #(
   parameter logic [7:0]  SOF     = 8'h7E,
   parameter int unsigned MAX_LEN = 64,
   parameter logic [15:0] POLY    = 16'h1021,
   parameter logic [15:0] INIT    = 16'hFFFF,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic [7:0]  payload_data_o,
   output logic        payload_valid_o,
   output logic        frame_done_o,
   output logic        frame_ok_o,
   output logic [1:0]  err_code_o,
   output logic [15:0] crc_calc_o,
   output logic [15:0] good_cnt_o,
   output logic [15:0] bad_cnt_o
);

   // The idle counter reads (cycles since last byte - 1), so firing one count
   // early lets the registered pulse land exactly TIMEOUT cycles after the byte.
   localparam int unsigned    TW        = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 2);
   localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_PAYLOAD, S_CRC_HI, S_CRC_LO, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   crc_q, crc_d;
   logic [7:0]    rem_q, rem_d;
   logic [7:0]    trl_hi_q, trl_hi_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    pdata_q, pdata_d;
   logic          pvalid_q, pvalid_d;
   logic          done_q, done_d;
   logic          ok_q, ok_d;
   logic [1:0]    err_q, err_d;
   logic [15:0]   crc_out_q, crc_out_d;
   logic [15:0]   good_q, good_d;
   logic [15:0]   bad_q, bad_d;
   logic          waiting;
   logic          fin;
   logic          fin_ok;
   logic [1:0]    fin_err;

   // MSB-first, non-reflected CRC-16 update for one byte
   function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      c = c_in ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ POLY) : (c << 1);
      end
      return c;
   endfunction

   // Register bank: state, CRC engine, timers and all registered outputs
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         crc_q     <= INIT;
         rem_q     <= '0;
         trl_hi_q  <= '0;
         tmo_q     <= '0;
         pdata_q   <= '0;
         pvalid_q  <= 1'b0;
         done_q    <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= '0;
         crc_out_q <= '0;
         good_q    <= '0;
         bad_q     <= '0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         rem_q     <= rem_d;
         trl_hi_q  <= trl_hi_d;
         tmo_q     <= tmo_d;
         pdata_q   <= pdata_d;
         pvalid_q  <= pvalid_d;
         done_q    <= done_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
         crc_out_q <= crc_out_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
      end
   end

   // Next-state, byte consumption, timeout and frame-status logic
   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      rem_d     = rem_q;
      trl_hi_d  = trl_hi_q;
      pdata_d   = pdata_q;
      pvalid_d  = 1'b0;
      done_d    = 1'b0;
      ok_d      = ok_q;
      err_d     = err_q;
      crc_out_d = crc_out_q;
      good_d    = good_q;
      bad_d     = bad_q;
      fin       = 1'b0;
      fin_ok    = 1'b0;
      fin_err   = 2'd0;

      waiting = (state_q == S_LEN) || (state_q == S_PAYLOAD) ||
                (state_q == S_CRC_HI) || (state_q == S_CRC_LO);
      tmo_d   = (rx_valid_i || !waiting) ? '0 : tmo_q + 1'b1;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (rx_valid_i && (rx_data_i == SOF)) begin
               crc_d   = INIT;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (rx_valid_i) begin
               if ((rx_data_i == 8'd0) || (rx_data_i > MAX_LEN_B)) begin
                  fin     = 1'b1;
                  fin_err = 2'd2;
                  state_d = S_IDLE;
               end else begin
                  rem_d   = rx_data_i;
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_valid_i) begin
               crc_d    = crc_upd(crc_q, rx_data_i);
               pdata_d  = rx_data_i;
               pvalid_d = 1'b1;
               rem_d    = rem_q - 8'd1;
               if (rem_q == 8'd1) state_d = S_CRC_HI;
            end
         end
         S_CRC_HI: begin
            if (rx_valid_i) begin
               trl_hi_d = rx_data_i;
               state_d  = S_CRC_LO;
            end
         end
         S_CRC_LO: begin
            if (rx_valid_i) begin
               fin     = 1'b1;
               fin_ok  = (crc_q == {trl_hi_q, rx_data_i});
               fin_err = fin_ok ? 2'd0 : 2'd1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A byte arriving on the limit cycle suppresses the timeout
      if (waiting && !rx_valid_i && (tmo_q == TMO_LAST)) begin
         fin     = 1'b1;
         fin_ok  = 1'b0;
         fin_err = 2'd3;
         state_d = S_IDLE;
      end

      if (fin) begin
         done_d    = 1'b1;
         ok_d      = fin_ok;
         err_d     = fin_err;
         crc_out_d = crc_q;
         if (fin_ok) good_d = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
         else        bad_d  = (bad_q  == 16'hFFFF) ? bad_q  : bad_q  + 16'd1;
      end
   end

   assign payload_data_o  = pdata_q;
   assign payload_valid_o = pvalid_q;
   assign frame_done_o    = done_q;
   assign frame_ok_o      = ok_q;
   assign err_code_o      = err_q;
   assign crc_calc_o      = crc_out_q;
   assign good_cnt_o      = good_q;
   assign bad_cnt_o       = bad_q;

endmodule
